// File: rtl/pushbutton_op_latch.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_op_latch
// Description : Synchronizes and debounces four pushbuttons, priority-resolves
//               presses and latches a one-hot op select plus A/B operands.
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_op_latch #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int DATA_W          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        pb_raw,
    input  logic [DATA_W-1:0] sw_a,
    input  logic [DATA_W-1:0] sw_b,
    output logic [3:0]        op_onehot,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              op_valid,
    output logic              busy
);

    localparam int            c_NUM_PB   = 4;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_PRESSED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    logic [c_NUM_PB-1:0] r_sync1_q, w_sync1_d;
    logic [c_NUM_PB-1:0] r_sync2_q, w_sync2_d;

    always_comb begin
        w_sync1_d = pb_raw;
        w_sync2_d = r_sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: the stable level flips only after the synced
    // level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic [c_NUM_PB-1:0] r_stable_q, w_stable_d;

    for (genvar gi = 0; gi < c_NUM_PB; gi++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
        logic             w_flip;

        always_comb begin
            w_cnt_d = '0;
            w_flip  = 1'b0;
            if (r_sync2_q[gi] != r_stable_q[gi]) begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_flip = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt_q <= '0;
            end else begin
                r_cnt_q <= w_cnt_d;
            end
        end

        assign w_stable_d[gi] = r_stable_q[gi] ^ w_flip;
    end

    // ------------------------------------------------------------------
    // Press detection: rising edge of the stable level, resolved so that
    // the highest-index button wins and the others are dropped.
    // ------------------------------------------------------------------
    logic [c_NUM_PB-1:0] r_prev_q, w_prev_d;
    logic [c_NUM_PB-1:0] r_press_q, w_press_d;
    logic [c_NUM_PB-1:0] w_rise;

    always_comb begin
        w_prev_d  = r_stable_q;
        w_rise    = r_stable_q & ~r_prev_q;
        w_press_d = '0;
        if (w_rise[3]) begin
            w_press_d = 4'b1000;
        end else if (w_rise[2]) begin
            w_press_d = 4'b0100;
        end else if (w_rise[1]) begin
            w_press_d = 4'b0010;
        end else if (w_rise[0]) begin
            w_press_d = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_q <= '0;
            r_prev_q   <= '0;
            r_press_q  <= '0;
        end else begin
            r_stable_q <= w_stable_d;
            r_prev_q   <= w_prev_d;
            r_press_q  <= w_press_d;
        end
    end

    // ------------------------------------------------------------------
    // Op latch FSM
    // ------------------------------------------------------------------
    state_t              r_state_q, w_state_d;
    logic [c_NUM_PB-1:0] r_op_q, w_op_d;
    logic [DATA_W-1:0]   r_a_q, w_a_d;
    logic [DATA_W-1:0]   r_b_q, w_b_d;
    logic                r_valid_q, w_valid_d;

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_valid_d = 1'b0;
        case (r_state_q)
            ST_IDLE, ST_HELD: begin
                if (|r_press_q) begin
                    w_state_d = ST_PRESSED;
                    w_op_d    = r_press_q;
                    w_a_d     = sw_a;
                    w_b_d     = sw_b;
                    w_valid_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release keeps the latched op; only a later press replaces it.
                if (r_stable_q == '0) begin
                    w_state_d = ST_HELD;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_op_q    <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign op_onehot = r_op_q;
    assign a_out     = r_a_q;
    assign b_out     = r_b_q;
    assign op_valid  = r_valid_q;
    assign busy      = (r_state_q == ST_PRESSED);

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_op_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pushbutton_op_latch
// Description : Directed self-checking bench for pushbutton_op_latch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_op_latch;

    localparam int c_DW = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      pb_raw;
    logic [c_DW-1:0] sw_a;
    logic [c_DW-1:0] sw_b;
    logic [3:0]      op_onehot;
    logic [c_DW-1:0] a_out;
    logic [c_DW-1:0] b_out;
    logic            op_valid;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_double = 0;
    int v0;
    bit seen;
    logic r_valid_prev = 1'b0;

    pushbutton_op_latch #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W          (5),
        .DATA_W         (c_DW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb_raw   (pb_raw),
        .sw_a     (sw_a),
        .sw_b     (sw_b),
        .op_onehot(op_onehot),
        .a_out    (a_out),
        .b_out    (b_out),
        .op_valid (op_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of op_valid pulses and of back-to-back pulses.
    always @(posedge clk) begin
        if (op_valid) n_valid++;
        if (op_valid && r_valid_prev) n_double++;
        r_valid_prev = op_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (op_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pb_raw = 4'b0000;
        sw_a   = '0;
        sw_b   = '0;
        tick(2);
        check("rst_op",    op_onehot, 4'b0000);
        check("rst_a",     a_out,     4'h0);
        check("rst_b",     b_out,     4'h0);
        check("rst_valid", op_valid,  1'b0);
        check("rst_busy",  busy,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Clean press of button one; next posedge is edge 0.
        @(negedge clk);
        pb_raw = 4'b0001;
        sw_a   = 4'd5;
        sw_b   = 4'd3;
        tick(19);
        check("lat_e18_valid", op_valid, 1'b0);
        tick(1);
        check("lat_e19_valid", op_valid,  1'b1);
        check("lat_e19_op",    op_onehot, 4'b0001);
        check("lat_e19_a",     a_out,     4'd5);
        check("lat_e19_b",     b_out,     4'd3);
        check("lat_e19_busy",  busy,      1'b1);
        tick(1);
        check("lat_e20_valid", op_valid,  1'b0);
        @(negedge clk);
        pb_raw = 4'b0000;
        tick(25);
        check("rel_busy", busy,      1'b0);
        check("rel_op",   op_onehot, 4'b0001);
        check("rel_a",    a_out,     4'd5);
        check("rel_b",    b_out,     4'd3);

        // Bouncing button three, then held steady.
        v0 = n_valid;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            pb_raw = k[0] ? 4'b0000 : 4'b0100;
            repeat (5) @(negedge clk);
        end
        pb_raw = 4'b0100;
        tick(30);
        check("bounce_count", n_valid - v0, 1);
        check("bounce_op",    op_onehot,    4'b0100);
        @(negedge clk);
        pb_raw = 4'b0000;
        tick(25);

        // 15-cycle pulse never survives debounce.
        v0 = n_valid;
        @(negedge clk);
        pb_raw = 4'b1000;
        repeat (15) @(negedge clk);
        pb_raw = 4'b0000;
        tick(30);
        check("short_count", n_valid - v0, 0);
        check("short_op",    op_onehot,    4'b0100);

        // Simultaneous presses resolve to the highest index.
        v0 = n_valid;
        @(negedge clk);
        pb_raw = 4'b1011;
        sw_a   = 4'd9;
        sw_b   = 4'd6;
        tick(25);
        check("simul_op",    op_onehot,    4'b1000);
        check("simul_count", n_valid - v0, 1);
        check("simul_a",     a_out,        4'd9);
        @(negedge clk);
        pb_raw = 4'b0000;
        tick(25);

        // Lockout: second button while first still held.
        @(negedge clk);
        pb_raw = 4'b0010;
        sw_a   = 4'd1;
        sw_b   = 4'd2;
        tick(25);
        check("lock_first_op", op_onehot, 4'b0010);
        v0 = n_valid;
        @(negedge clk);
        pb_raw = 4'b0110;
        sw_a   = 4'd7;
        sw_b   = 4'd8;
        tick(40);
        check("lock_op",    op_onehot,    4'b0010);
        check("lock_count", n_valid - v0, 0);
        check("lock_busy",  busy,         1'b1);
        check("lock_a",     a_out,        4'd1);
        @(negedge clk);
        pb_raw = 4'b0000;
        tick(25);
        check("lock_rel_busy", busy, 1'b0);
        v0 = n_valid;
        @(negedge clk);
        pb_raw = 4'b0100;
        tick(25);
        check("repress_op",    op_onehot,    4'b0100);
        check("repress_a",     a_out,        4'd7);
        check("repress_b",     b_out,        4'd8);
        check("repress_count", n_valid - v0, 1);
        @(negedge clk);
        pb_raw = 4'b0000;
        tick(25);

        // Switch changes while HELD stay invisible.
        v0 = n_valid;
        @(negedge clk);
        sw_a = 4'd15;
        sw_b = 4'd14;
        tick(30);
        check("iso_a",     a_out,        4'd7);
        check("iso_b",     b_out,        4'd8);
        check("iso_count", n_valid - v0, 0);
        check("iso_busy",  busy,         1'b0);

        // Asynchronous reset mid-cycle, with button one held through it.
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        pb_raw = 4'b0001;
        #1;
        check("arst_op",    op_onehot, 4'b0000);
        check("arst_a",     a_out,     4'h0);
        check("arst_b",     b_out,     4'h0);
        check("arst_valid", op_valid,  1'b0);
        check("arst_busy",  busy,      1'b0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(40, seen);
        check("held_rst_seen", seen,      1'b1);
        check("held_rst_op",   op_onehot, 4'b0001);
        check("held_rst_a",    a_out,     4'd15);
        tick(2);
        check("no_double_valid", n_double, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
